// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of the dual-bank data memory: checks the effective address,
// holds the memory controls for the full access latency, and returns a tagged response.
module lsu_mem_ctrl #(
  parameter int LOAD_LAT  = 3,
  parameter int STORE_LAT = 3,
  parameter int ADDR_W    = 11,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [2:0]        mem_op_code,
  output logic [ADDR_W-1:0] mem_rwaddr,
  output logic [31:0]       mem_wdata,
  output logic              mem_stall,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 8;
  localparam logic [2:0] OP_IDLE = 3'b011;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [31:0]        eff;
  logic               req_err;
  logic               accept;
  logic               last;
  logic [2:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    eff = req_base + {{20{req_offset[11]}}, req_offset};
  end

  always_comb begin
    req_err = |eff[31:ADDR_W];
    case (req_op)
      3'b001, 3'b101: if (eff[0]) req_err = 1'b1;
      3'b010, 3'b111: if (|eff[1:0]) req_err = 1'b1;
      3'b011, 3'b110: req_err = 1'b1;
      default: ;
    endcase
  end

  assign accept = req_valid && (state == IDLE);
  assign last   = (cnt == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  if (last) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    resp_valid  = (state == RESP);
    mem_stall   = (state != ACCESS);
    mem_op_code = (state == ACCESS) ? op_q : OP_IDLE;
    mem_rwaddr  = addr_q;
    mem_wdata   = wdata_q;
  end

  // Memory-side fields are only latched for legal requests so an erroring request never moves them.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q       <= OP_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_tag   <= '0;
    end else if (accept) begin
      if (req_err) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
        resp_tag   <= req_tag;
      end else begin
        op_q    <= req_op;
        addr_q  <= eff[ADDR_W-1:0];
        wdata_q <= req_wdata;
        tag_q   <= req_tag;
        cnt     <= req_op[2] ? CNT_W'(STORE_LAT) : CNT_W'(LOAD_LAT);
      end
    end else if (state == ACCESS) begin
      if (last) begin
        resp_rdata <= op_q[2] ? '0 : mem_rdata;
        resp_err   <= 1'b0;
        resp_tag   <= tag_q;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-array memory with fixed-latency behaviour plus a
// request-level reference model for address checks, latency and returned data.
module tb_lsu_mem_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_base = '0;
  logic [11:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  resp_tag;
  logic [2:0]  mem_op_code;
  logic [10:0] mem_rwaddr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [7:0]  mem_b [0:2047];
  int unsigned acc_cnt;

  logic [2:0]  q_op;
  logic [31:0] q_base;
  logic [11:0] q_off;
  logic [31:0] q_wdata;
  logic [3:0]  q_tag;

  lsu_mem_ctrl #(.LOAD_LAT(3), .STORE_LAT(3), .ADDR_W(11), .TAG_W(4)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_tag(resp_tag),
    .mem_op_code(mem_op_code), .mem_rwaddr(mem_rwaddr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] op, input int unsigned a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_b[a];
    b1 = mem_b[(a + 1) % 2048];
    b2 = mem_b[(a + 2) % 2048];
    b3 = mem_b[(a + 3) % 2048];
    case (op)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // Memory: result visible LAT cycles after op_code first appears, garbage otherwise;
  // stores land at the end of the access.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_cnt <= 0;
    end else if (mem_op_code != 3'b011 && !mem_stall) begin
      if (acc_cnt == LAT - 1 && !mem_op_code[2])
        mem_rdata <= load_val(mem_op_code, int'(mem_rwaddr));
      else
        mem_rdata <= $urandom;
      if (acc_cnt == LAT - 1 && mem_op_code[2]) begin
        mem_b[mem_rwaddr] = mem_wdata[7:0];
        if (mem_op_code != 3'b100) mem_b[mem_rwaddr + 11'd1] = mem_wdata[15:8];
        if (mem_op_code == 3'b111) begin
          mem_b[mem_rwaddr + 11'd2] = mem_wdata[23:16];
          mem_b[mem_rwaddr + 11'd3] = mem_wdata[31:24];
        end
      end
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt   <= 0;
      mem_rdata <= $urandom;
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] base, input logic [11:0] off,
                        input logic [31:0] wd, input logic [3:0] tag,
                        input int unsigned hold, input bit queue_next);
    longint e;
    logic [31:0] eff, exp_rd;
    int unsigned sz, w;
    bit err;
    e = longint'(base) + longint'($signed(off));
    eff = e[31:0];
    case (op)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010, 3'b111: sz = 4;
      default:        sz = 0;
    endcase
    err = (sz == 0) || (eff >= 32'd2048) || ((eff % sz) != 0);
    exp_rd = (err || op[2]) ? 32'd0 : load_val(op, eff % 2048);

    req_op = op; req_base = base; req_offset = off; req_wdata = wd; req_tag = tag;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (err) begin
      check("err_latency", 32'(resp_valid), 32'd1);
      check("err_stall", 32'(mem_stall), 32'd1);
      check("err_opcode", 32'(mem_op_code), 32'd3);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        check("acc_no_resp", 32'(resp_valid), 32'd0);
        check("acc_opcode", 32'(mem_op_code), 32'(op));
        check("acc_addr", 32'(mem_rwaddr), eff % 2048);
        check("acc_stall", 32'(mem_stall), 32'd0);
        check("acc_wdata", mem_wdata, wd);
        check("acc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      check("resp_latency", 32'(resp_valid), 32'd1);
      check("post_stall", 32'(mem_stall), 32'd1);
      check("post_opcode", 32'(mem_op_code), 32'd3);
    end
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", 32'(resp_err), 32'(err));
    check("resp_tag", 32'(resp_tag), 32'(tag));
    check("resp_busy", 32'(busy), 32'd1);

    if (queue_next) begin
      req_op = q_op; req_base = q_base; req_offset = q_off; req_wdata = q_wdata; req_tag = q_tag;
      req_valid = 1'b1;
    end
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", 32'(resp_err), 32'(err));
      check("hold_tag", 32'(resp_tag), 32'(tag));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("done_valid", 32'(resp_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110};
    for (int i = 0; i < 2048; i++) mem_b[i] = 8'($urandom);

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_opcode", 32'(mem_op_code), 32'd3);
    check("rst_stall", 32'(mem_stall), 32'd1);
    check("rst_addr", 32'(mem_rwaddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_tag", 32'(resp_tag), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    do_req(3'b111, 32'h100, 12'h000, 32'h80FF7F01, 4'd1, 0, 1'b0);
    do_req(3'b111, 32'h100, 12'h004, 32'hDEADBEEF, 4'd3, 0, 1'b0);
    do_req(3'b000, 32'h104, 12'hFFF, 32'h0, 4'd5, 0, 1'b0);
    do_req(3'b001, 32'h102, 12'h000, 32'h0, 4'd6, 1, 1'b0);
    do_req(3'b010, 32'h0FC, 12'h004, 32'h0, 4'd7, 0, 1'b0);
    do_req(3'b010, 32'h104, 12'h000, 32'h0, 4'd8, 0, 1'b0);
    do_req(3'b010, 32'h102, 12'h000, 32'h0, 4'd10, 0, 1'b0);
    do_req(3'b101, 32'h001, 12'h000, 32'h1234, 4'd11, 0, 1'b0);
    do_req(3'b000, 32'h7FF, 12'h001, 32'h0, 4'd12, 0, 1'b0);
    do_req(3'b110, 32'h100, 12'h000, 32'h0, 4'd13, 0, 1'b0);

    q_op = 3'b010; q_base = 32'h104; q_off = 12'h000; q_wdata = 32'h0; q_tag = 4'd9;
    do_req(3'b000, 32'h100, 12'h000, 32'h0, 4'd14, 5, 1'b1);
    do_req(q_op, q_base, q_off, q_wdata, q_tag, 0, 1'b0);

    // Reset during the second ACCESS cycle of a load.
    req_op = 3'b010; req_base = 32'h100; req_offset = 12'h0; req_tag = 4'd2; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_opcode_before", 32'(mem_op_code), 32'd2);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid_rst_opcode", 32'(mem_op_code), 32'd3);
    check("mid_rst_stall", 32'(mem_stall), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(3'b010, 32'h100, 12'h000, 32'h0, 4'd4, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [31:0] base;
      op = ops[$urandom_range(0, 7)];
      base = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2047));
      do_req(op, base, 12'($urandom), 32'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer that sits directly upstream of the 2 KB dual-bank data memory in the MEM stage.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Computes and checks the effective address, then drives the memory's op_code/rwaddr/wdata/stall and holds them stable for the memory's full pipelined latency.
- Returns the loaded word, or store completion, on a valid/ready response channel.

Parameters:
- LOAD_LAT, 3, cycles from the first cycle op_code is presented until mem_rdata holds the load result.
- STORE_LAT, 3, cycles from the first cycle a store op_code is presented until the bank write has completed.
- ADDR_W, 11, memory byte-address width; the upper bit selects the bank.
- TAG_W, 4, request tag width, returned unchanged with the response.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_op  input  3  000 LB, 001 LH, 010 LW, 100 SB, 101 SH, 111 SW; 011 and 110 are illegal.
- req_base  input  32  base register value.
- req_offset  input  12  signed immediate offset.
- req_wdata  input  32  store data; the low byte or low half is used for SB/SH.
- req_tag  input  TAG_W  request identifier.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  sign-extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal-op request.
- resp_tag  output  TAG_W  tag of the completed request.
- mem_op_code  output  3  to memory op_code.
- mem_rwaddr  output  ADDR_W  to memory rwaddr.
- mem_wdata  output  32  to memory wdata.
- mem_stall  output  1  to memory stall; 1 blocks writes.
- mem_rdata  input  32  from memory rdata.
- busy  output  1  high in ACCESS or RESP.

Behaviour:
- Reset (async):
  - state = IDLE, counter = 0.
  - mem_op_code = 3'b011 (idle code: no read, no write; the memory's rdata holds its value).
  - mem_rwaddr = 0, mem_wdata = 0, mem_stall = 1.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, resp_tag = 0, busy = 0; req_ready follows state and is 1 immediately.
- Effective address: eff = req_base + sign-extended req_offset, 32-bit, wraps modulo 2^32.
- Error checks, evaluated at acceptance:
  - err = 1 if eff[31:ADDR_W] != 0.
  - err = 1 if LH/SH and eff[0] = 1.
  - err = 1 if LW/SW and eff[1:0] != 0.
  - err = 1 if req_op is 011 or 110.
- IDLE:
  - req_ready = 1, mem_stall = 1, mem_op_code = 011.
  - On req_valid && req_ready: latch op, eff[ADDR_W-1:0], wdata and tag.
  - If err: go to RESP with resp_err = 1, resp_rdata = 0. The memory is never touched.
  - Otherwise: go to ACCESS and load counter = LAT (LOAD_LAT for loads, STORE_LAT for stores).
- ACCESS:
  - req_ready = 0, mem_stall = 0.
  - mem_op_code, mem_rwaddr and mem_wdata carry the latched values, constant for every ACCESS cycle.
  - counter decrements each cycle. Total ACCESS duration = LAT + 1 cycles.
  - On the cycle counter = 0:
    - Loads: mem_rdata is captured into resp_rdata.
    - Stores: resp_rdata = 0.
  - Then go to RESP with resp_err = 0.
  - mem_op_code returns to 011 and mem_stall to 1 on the cycle after leaving ACCESS.
- RESP:
  - resp_valid = 1; resp_rdata, resp_err and resp_tag are stable while resp_ready = 0.
  - On resp_ready: go to IDLE next cycle, resp_valid = 0.
- Latency with defaults, request accepted at edge E0:
  - Load or store: resp_valid rises at E0 + 5 edges (1 to enter ACCESS + 4 ACCESS cycles).
  - Error: resp_valid rises at E0 + 1.
- No overlap: at most one request is outstanding, and a new request is accepted only after the response handshake. req_valid arriving while busy is ignored (req_ready = 0); the requester must hold it.
- Reset mid-ACCESS: the operation is aborted immediately, outputs go to reset values, and no response is produced. A partially issued store may or may not have been written.
- mem_rdata is ignored except on the capture cycle.

Test Plan:
- Reset, then SW base=0x100 off=0x004 wdata=0xDEADBEEF, tag=3 -> mem_rwaddr=0x104, mem_op_code=111 and mem_stall=0 held for 4 cycles; resp_valid at E0+5 with rdata=0, err=0, tag=3.
- LB base=0x104 off=-1 (0xFFF) with memory word 0x80FF7F01 at 0x100 -> mem_rwaddr=0x103; resp_rdata=0xFFFFFF80.
- LH eff=0x102 on word 0x80FF7F01 -> resp_rdata=0xFFFF80FF; LW eff=0x100 -> 0x80FF7F01.
- Error cases, each with resp_err=1 at E0+1, mem_stall staying 1 and mem_op_code staying 011:
  - LW eff=0x102.
  - SH eff=0x001.
  - LB eff=0x800.
  - op=110.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid -> response fields stable and req_ready=0; a queued req_valid is accepted on the cycle after resp_ready=1.
- Assert nrst during ACCESS cycle 2 of a load -> same-cycle async clear: mem_op_code=011, mem_stall=1, no resp_valid; a subsequent LW completes normally.
